// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I pipeline definitions used by the writeback stage.
//   result_sel_t : writeback result source select
//   F3_*         : funct3 encodings for loads
//   REG_ZERO     : architectural x0 index
package rv_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_sel_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational lane select and sign/zero extension of a load.
//   funct3      in  3   load size and signedness
//   byte_offset in  2   load address bits [1:0], selects byte/half lane
//   word        in  32  raw aligned memory word
//   result      out 32  extended load value
// LW and the undefined funct3 codes pass the word through unchanged.
module load_extend
  import rv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_offset,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = 8'h00;
    case (byte_offset)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
  end

  // Halfword lane is chosen by bit 1 only; bit 0 is ignored.
  assign sel_half = byte_offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = word;
    case (funct3)
      F3_LB:   result = {{24{sel_byte[7]}}, sel_byte};
      F3_LBU:  result = {24'h000000, sel_byte};
      F3_LH:   result = {{16{sel_half[15]}}, sel_half};
      F3_LHU:  result = {16'h0000, sel_half};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final RV32I pipeline stage, sole writer of the register file.
//   clock_i, reset_n_i             clock (rising edge), async active-low reset
//   valid_i, stall_i, flush_i      MEM-stage valid, hold WB entry, kill WB entry
//   reg_write_i, rd_i              instruction writes rd
//   result_sel_i                   00 ALU, 01 load, 10 PC+4, 11 immediate
//   funct3_i, byte_offset_i        load size/sign and lane
//   alu_result_i, load_word_i,
//   pc_plus4_i, imm_i              result candidates
//   rd_register_1_i/2_i            decode read addresses for bypass
//   reg_write_o, wr_register_o,
//   wr_data_o                      register file write port
//   fwd_1_o/2_o, fwd_data_1_o/2_o  same-cycle bypass hit and data to decode
//   retired_o                      retired-instruction count (wraps)
//
// Flow control: MEM presents an instruction when valid_i=1. There is no ready
// back-pressure; instead stall_i=1 holds the WB entry (and MEM must hold its
// own state), and flush_i=1 kills the WB entry and overrides stall_i. An
// entry retires at the edge where it is valid and neither stalled nor flushed.
module writeback_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              reg_write_i,
  input  logic [4:0]        rd_i,
  input  logic [1:0]        result_sel_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        byte_offset_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   load_word_i,
  input  logic [XLEN-1:0]   pc_plus4_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [4:0]        rd_register_1_i,
  input  logic [4:0]        rd_register_2_i,
  output logic              reg_write_o,
  output logic [4:0]        wr_register_o,
  output logic [XLEN-1:0]   wr_data_o,
  output logic              fwd_1_o,
  output logic              fwd_2_o,
  output logic [XLEN-1:0]   fwd_data_1_o,
  output logic [XLEN-1:0]   fwd_data_2_o,
  output logic [CNT_W-1:0]  retired_o
);

  logic [31:0]      load_data;
  logic [XLEN-1:0]  final_data;
  result_sel_t      sel;

  logic             valid_q;
  logic             reg_write_q;
  logic [4:0]       rd_q;
  logic [XLEN-1:0]  data_q;
  logic [CNT_W-1:0] retired_q;

  logic             retire;

  load_extend u_load_extend (
    .funct3      (funct3_i),
    .byte_offset (byte_offset_i),
    .word        (load_word_i),
    .result      (load_data)
  );

  assign sel = result_sel_t'(result_sel_i);

  // Result selection happens before the entry register so the WB entry
  // already holds the final architectural value.
  always_comb begin
    final_data = alu_result_i;
    case (sel)
      RES_ALU:  final_data = alu_result_i;
      RES_LOAD: final_data = load_data;
      RES_PC4:  final_data = pc_plus4_i;
      RES_IMM:  final_data = imm_i;
      default:  final_data = alu_result_i;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= REG_ZERO;
      data_q      <= '0;
    end else if (flush_i) begin
      valid_q     <= 1'b0;
    end else if (!stall_i) begin
      valid_q     <= valid_i;
      reg_write_q <= reg_write_i;
      rd_q        <= rd_i;
      data_q      <= final_data;
    end
  end

  // Count the entry leaving WB; a stalled entry is counted once, on release.
  assign retire = valid_q & ~stall_i & ~flush_i;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  // Writes to x0 never reach the register file. During a stall the same
  // write is repeated every cycle, which is harmless.
  assign reg_write_o   = valid_q & reg_write_q & (rd_q != REG_ZERO);
  assign wr_register_o = rd_q;
  assign wr_data_o     = data_q;

  // Bypass covers decode reading the register file in the cycle the write
  // is pending; only registered state feeds the data path.
  assign fwd_1_o      = reg_write_o & (rd_q == rd_register_1_i);
  assign fwd_2_o      = reg_write_o & (rd_q == rd_register_2_i);
  assign fwd_data_1_o = data_q;
  assign fwd_data_2_o = data_q;

  assign retired_o = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  import rv_pkg::*;

  logic        clock_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        reg_write_i = 1'b0;
  logic [4:0]  rd_i = 5'd0;
  logic [1:0]  result_sel_i = 2'b00;
  logic [2:0]  funct3_i = 3'b000;
  logic [1:0]  byte_offset_i = 2'b00;
  logic [31:0] alu_result_i = '0;
  logic [31:0] load_word_i = '0;
  logic [31:0] pc_plus4_i = '0;
  logic [31:0] imm_i = '0;
  logic [4:0]  rd_register_1_i = 5'd0;
  logic [4:0]  rd_register_2_i = 5'd0;
  logic        reg_write_o;
  logic [4:0]  wr_register_o;
  logic [31:0] wr_data_o;
  logic        fwd_1_o;
  logic        fwd_2_o;
  logic [31:0] fwd_data_1_o;
  logic [31:0] fwd_data_2_o;
  logic [63:0] retired_o;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_ret = '0;

  writeback_stage dut (
    .clock_i         (clock_i),
    .reset_n_i       (reset_n_i),
    .valid_i         (valid_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .reg_write_i     (reg_write_i),
    .rd_i            (rd_i),
    .result_sel_i    (result_sel_i),
    .funct3_i        (funct3_i),
    .byte_offset_i   (byte_offset_i),
    .alu_result_i    (alu_result_i),
    .load_word_i     (load_word_i),
    .pc_plus4_i      (pc_plus4_i),
    .imm_i           (imm_i),
    .rd_register_1_i (rd_register_1_i),
    .rd_register_2_i (rd_register_2_i),
    .reg_write_o     (reg_write_o),
    .wr_register_o   (wr_register_o),
    .wr_data_o       (wr_data_o),
    .fwd_1_o         (fwd_1_o),
    .fwd_2_o         (fwd_2_o),
    .fwd_data_1_o    (fwd_data_1_o),
    .fwd_data_2_o    (fwd_data_2_o),
    .retired_o       (retired_o)
  );

  // Clock
  always #5 clock_i = ~clock_i;

  // Driver tasks
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic rw, input logic [4:0] rd,
                           input logic [1:0] sel, input logic [31:0] val);
    valid_i      = v;
    reg_write_i  = rw;
    rd_i         = rd;
    result_sel_i = sel;
    alu_result_i = val;
    pc_plus4_i   = val;
    imm_i        = val;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({reg_write_o, wr_register_o, wr_data_o, fwd_1_o, fwd_2_o} !== '0) begin
      failures++;
      $display("FAIL reset_wr: rw=%0b reg=%0d data=%h fwd=%0b%0b, required all 0",
               reg_write_o, wr_register_o, wr_data_o, fwd_1_o, fwd_2_o);
    end
    checks++;
    if (retired_o !== 64'd0 || fwd_data_1_o !== 32'd0 || fwd_data_2_o !== 32'd0) begin
      failures++;
      $display("FAIL reset_cnt: retired=%0d fwd_data=%h/%h, required 0", retired_o,
               fwd_data_1_o, fwd_data_2_o);
    end
    @(negedge clock_i);
    reset_n_i = 1'b1;
    tick();
  endtask

  task automatic test_alu_write();
    set_instr(1'b1, 1'b1, 5'd1, RES_ALU, 32'h55555555);
    tick();
    checks++;
    if (reg_write_o !== 1'b1 || wr_register_o !== 5'd1 || wr_data_o !== 32'h55555555) begin
      failures++;
      $display("FAIL alu_write: rw=%0b reg=%0d data=%h, required 1/1/55555555",
               reg_write_o, wr_register_o, wr_data_o);
    end
    set_instr(1'b0, 1'b0, 5'd0, RES_ALU, 32'h0);
    tick();
    exp_ret += 1;
    checks++;
    if (retired_o !== exp_ret || reg_write_o !== 1'b0) begin
      failures++;
      $display("FAIL alu_retire: retired=%0d rw=%0b, required %0d/0",
               retired_o, reg_write_o, exp_ret);
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3  [9] = '{F3_LB, F3_LB, F3_LB, F3_LB, F3_LHU, F3_LH, F3_LW, F3_LBU, 3'b011};
    logic [1:0]  off [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1};
    logic [31:0] exp [9] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80,
                             32'h000080FF, 32'hFFFF80FF, 32'h80FF7F01, 32'h00000080,
                             32'h80FF7F01};
    load_word_i = 32'h80FF7F01;
    for (int i = 0; i < 9; i++) begin
      set_instr(1'b1, 1'b1, 5'd3, RES_LOAD, 32'h0);
      funct3_i      = f3[i];
      byte_offset_i = off[i];
      tick();
      checks++;
      if (wr_data_o !== exp[i] || reg_write_o !== 1'b1) begin
        failures++;
        $display("FAIL load_ext[%0d]: f3=%b off=%0d data=%h rw=%0b, required %h/1",
                 i, f3[i], off[i], wr_data_o, reg_write_o, exp[i]);
      end
    end
    set_instr(1'b0, 1'b0, 5'd0, RES_ALU, 32'h0);
    funct3_i = 3'b000;
    byte_offset_i = 2'd0;
    tick();
    exp_ret += 9;
    checks++;
    if (retired_o !== exp_ret) begin
      failures++;
      $display("FAIL load_retire: retired=%0d, required %0d", retired_o, exp_ret);
    end
  endtask

  task automatic test_result_sel();
    set_instr(1'b1, 1'b1, 5'd8, RES_PC4, 32'h0);
    pc_plus4_i = 32'h00001004;
    tick();
    checks++;
    if (wr_data_o !== 32'h00001004) begin
      failures++;
      $display("FAIL sel_pc4: data=%h, required 00001004", wr_data_o);
    end
    set_instr(1'b1, 1'b1, 5'd9, RES_IMM, 32'h0);
    imm_i = 32'hDEAD0000;
    tick();
    checks++;
    if (wr_data_o !== 32'hDEAD0000 || wr_register_o !== 5'd9) begin
      failures++;
      $display("FAIL sel_imm: data=%h reg=%0d, required DEAD0000/9", wr_data_o, wr_register_o);
    end
    // Instruction with no register write still retires.
    set_instr(1'b1, 1'b0, 5'd10, RES_ALU, 32'h11111111);
    tick();
    checks++;
    if (reg_write_o !== 1'b0) begin
      failures++;
      $display("FAIL no_write: rw=%0b, required 0", reg_write_o);
    end
    set_instr(1'b0, 1'b0, 5'd0, RES_ALU, 32'h0);
    tick();
    exp_ret += 3;
    checks++;
    if (retired_o !== exp_ret) begin
      failures++;
      $display("FAIL sel_retire: retired=%0d, required %0d", retired_o, exp_ret);
    end
  endtask

  task automatic test_x0_bypass();
    rd_register_1_i = 5'd0;
    rd_register_2_i = 5'd0;
    set_instr(1'b1, 1'b1, 5'd0, RES_ALU, 32'h12345678);
    tick();
    checks++;
    if (reg_write_o !== 1'b0 || fwd_1_o !== 1'b0 || fwd_2_o !== 1'b0) begin
      failures++;
      $display("FAIL x0_suppress: rw=%0b fwd=%0b%0b, required 0/00", reg_write_o, fwd_1_o, fwd_2_o);
    end
    set_instr(1'b1, 1'b1, 5'd2, RES_ALU, 32'hAAAAAAAA);
    rd_register_1_i = 5'd2;
    rd_register_2_i = 5'd2;
    tick();
    checks++;
    if (fwd_1_o !== 1'b1 || fwd_2_o !== 1'b1 || fwd_data_1_o !== 32'hAAAAAAAA ||
        fwd_data_2_o !== 32'hAAAAAAAA) begin
      failures++;
      $display("FAIL bypass_both: fwd=%0b%0b data=%h/%h, required 11 AAAAAAAA",
               fwd_1_o, fwd_2_o, fwd_data_1_o, fwd_data_2_o);
    end
    set_instr(1'b0, 1'b0, 5'd0, RES_ALU, 32'h0);
    rd_register_2_i = 5'd5;
    #1;
    checks++;
    if (fwd_1_o !== 1'b1 || fwd_2_o !== 1'b0) begin
      failures++;
      $display("FAIL bypass_one: fwd=%0b%0b, required 10", fwd_1_o, fwd_2_o);
    end
    tick();
    exp_ret += 2;
    checks++;
    if (retired_o !== exp_ret || fwd_1_o !== 1'b0) begin
      failures++;
      $display("FAIL bypass_retire: retired=%0d fwd1=%0b, required %0d/0",
               retired_o, fwd_1_o, exp_ret);
    end
    rd_register_1_i = 5'd0;
    rd_register_2_i = 5'd0;
  endtask

  task automatic test_stall();
    set_instr(1'b1, 1'b1, 5'd4, RES_ALU, 32'hCAFEF00D);
    tick();
    set_instr(1'b1, 1'b1, 5'd5, RES_ALU, 32'h0BADBEEF);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (reg_write_o !== 1'b1 || wr_register_o !== 5'd4 || wr_data_o !== 32'hCAFEF00D ||
          retired_o !== exp_ret) begin
        failures++;
        $display("FAIL stall_hold[%0d]: rw=%0b reg=%0d data=%h retired=%0d, required 1/4/CAFEF00D/%0d",
                 i, reg_write_o, wr_register_o, wr_data_o, retired_o, exp_ret);
      end
    end
    stall_i = 1'b0;
    set_instr(1'b0, 1'b0, 5'd0, RES_ALU, 32'h0);
    tick();
    exp_ret += 1;
    checks++;
    if (retired_o !== exp_ret || reg_write_o !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: retired=%0d rw=%0b, required %0d/0",
               retired_o, reg_write_o, exp_ret);
    end
  endtask

  task automatic test_flush_stall();
    set_instr(1'b1, 1'b1, 5'd6, RES_ALU, 32'h00000001);
    tick();
    set_instr(1'b0, 1'b0, 5'd0, RES_ALU, 32'h0);
    flush_i = 1'b1;
    stall_i = 1'b1;
    tick();
    checks++;
    if (reg_write_o !== 1'b0 || retired_o !== exp_ret) begin
      failures++;
      $display("FAIL flush_stall: rw=%0b retired=%0d, required 0/%0d",
               reg_write_o, retired_o, exp_ret);
    end
    flush_i = 1'b0;
    stall_i = 1'b0;
    tick();
    checks++;
    if (retired_o !== exp_ret) begin
      failures++;
      $display("FAIL flush_count: retired=%0d, required %0d", retired_o, exp_ret);
    end
  endtask

  task automatic test_reset_mid();
    set_instr(1'b1, 1'b1, 5'd7, RES_ALU, 32'h00000077);
    tick();
    checks++;
    if (reg_write_o !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: rw=%0b, required 1", reg_write_o);
    end
    stall_i = 1'b1;
    #2;
    reset_n_i = 1'b0;
    #1;
    checks++;
    if ({reg_write_o, wr_register_o, wr_data_o, fwd_1_o, fwd_2_o} !== '0 ||
        retired_o !== 64'd0) begin
      failures++;
      $display("FAIL async_reset: rw=%0b reg=%0d data=%h retired=%0d, required all 0",
               reg_write_o, wr_register_o, wr_data_o, retired_o);
    end
    set_instr(1'b0, 1'b0, 5'd0, RES_ALU, 32'h0);
    stall_i = 1'b0;
    @(negedge clock_i);
    reset_n_i = 1'b1;
    exp_ret = '0;
    tick();
    checks++;
    if (retired_o !== exp_ret || reg_write_o !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: retired=%0d rw=%0b, required 0/0", retired_o, reg_write_o);
    end
  endtask

  task automatic test_wrap();
    force dut.retired_q = {64{1'b1}};
    #1;
    release dut.retired_q;
    set_instr(1'b1, 1'b1, 5'd11, RES_ALU, 32'h0000000B);
    tick();
    set_instr(1'b0, 1'b0, 5'd0, RES_ALU, 32'h0);
    tick();
    checks++;
    if (retired_o !== 64'd0) begin
      failures++;
      $display("FAIL counter_wrap: retired=%h, required 0", retired_o);
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_alu_write();
    test_load_extend();
    test_result_sel();
    test_x0_bypass();
    test_stall();
    test_flush_stall();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
